pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage RISC-V pipeline. Every cycle it evaluates load-use hazards, taken branches/jumps resolved in EX, and instruction/data memory busy-wait. It then drives the hold and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small state machine guarantees exactly one bubble per load-use hazard and suppresses false hazard detection on flushed slots.

---
 rtl/pipeline_hazard_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for a 5-stage RISC-V pipeline.
// Priority each cycle is memory busy-wait, then taken branch in EX, then load-use.
// Ports:
//   CLK, RESET (synchronous, active-low)
//   ID_RS1/ID_RS2/ID_USES_RS1/ID_USES_RS2 : source operands of the instruction in ID
//   EX_MEM_READ/EX_RD                     : load in EX and its destination register
//   EX_BRANCH_TAKEN                       : PC redirect resolved in EX this cycle
//   IMEM_BUSY/DMEM_BUSY                   : memory busy-wait
//   *_STALL/*_FLUSH                       : hold/bubble controls for PC and pipeline registers
//   STALL_CNT/FLUSH_CNT                   : saturating statistics (only when PIPE_STATS_EN is defined)
// Optional feature macro: PIPE_STATS_EN
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic             EX_MEM_READ,
    input  logic [4:0]       EX_RD,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    output logic             PC_STALL,
    output logic             IFID_STALL,
    output logic             IFID_FLUSH,
    output logic             IDEX_STALL,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_STALL,
    output logic             MEMWB_STALL,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);
    typedef enum logic [1:0] {RUN, BUBBLE, FLUSHED, WAIT} state_t;
    state_t state, state_nxt;
    logic busy, lu, br_fire, lu_fire;
    always_comb begin
        busy    = IMEM_BUSY | DMEM_BUSY;
        // ID holds either the re-issued consumer or a flushed NOP in BUBBLE/FLUSHED, so no new hazard can exist there
        lu      = (state == RUN || state == WAIT) && EX_MEM_READ && EX_RD != 5'd0 &&
                  ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
        br_fire = !busy && EX_BRANCH_TAKEN;
        lu_fire = !busy && !EX_BRANCH_TAKEN && lu;
    end
    always_ff @(posedge CLK)
        state <= !RESET ? RUN : state_nxt;
    always_comb
        state_nxt = busy ? WAIT : EX_BRANCH_TAKEN ? FLUSHED : lu ? BUBBLE : RUN;
    // While RESET is low every stall drops and both flushes clear the pipeline registers
    always_comb begin
        PC_STALL    = RESET && (busy || lu_fire);
        IFID_STALL  = RESET && (busy || lu_fire);
        IDEX_STALL  = RESET && busy;
        EXMEM_STALL = RESET && busy;
        MEMWB_STALL = RESET && busy;
        IFID_FLUSH  = !RESET || br_fire;
        IDEX_FLUSH  = !RESET || br_fire || lu_fire;
    end
`ifdef PIPE_STATS_EN
    always_ff @(posedge CLK)
        if (!RESET) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (PC_STALL && !(&STALL_CNT)) STALL_CNT <= STALL_CNT + CNT_W'(1);
            if (br_fire && !(&FLUSH_CNT)) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
        end
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif
endmodule
